bist_seq: RTL
=============

BIST_SEQ -- requirements
Module: bist_seq

Interface
REQ-001 SHALL have parameter PI_W, default 12, meaning CUT primary-input width (pattern width).
REQ-002 SHALL have parameter PO_W, default 8, meaning CUT primary-output width (signature width).
REQ-003 SHALL have parameter CNT_W, default 16, meaning pattern-counter width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  meaning request to begin one test session; sampled only in IDLE.
REQ-007 SHALL have port num_pat  input  CNT_W  meaning patterns per session; sampled on accepted start.
REQ-008 SHALL have port seed  input  PI_W  meaning LFSR seed; sampled on accepted start.
REQ-009 SHALL have port golden  input  PO_W  meaning expected signature; sampled in DONE.
REQ-010 SHALL have port cut_pi  output  PI_W  meaning pattern driven into the combinational CUT.
REQ-011 SHALL have port cut_po  input  PO_W  meaning CUT response to cut_pi, valid in the same cycle.
REQ-012 SHALL have port busy  output  1  meaning high in RUN and DRAIN.
REQ-013 SHALL have port done  output  1  meaning one-cycle pulse in DONE.
REQ-014 SHALL have port pass  output  1  meaning signature==golden, updated in DONE, held until next accepted start.
REQ-015 SHALL have port signature  output  PO_W  meaning current MISR contents.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> [DRAIN] -> DONE -> IDLE.
REQ-017 SHALL, on start in IDLE: load LFSR with seed (0x001 if seed==0), clear MISR and counter, clear pass, go RUN; if num_pat==0, go DONE instead.
REQ-018 SHALL drive cut_pi = LFSR value in RUN; cut_pi holds its last value outside RUN.
REQ-019 SHALL step the LFSR each RUN cycle: Fibonacci, polynomial x^12+x^6+x^4+x+1, next = {lfsr[10:0], lfsr[11]^lfsr[5]^lfsr[3]^lfsr[0]}.
REQ-020 SHALL update the MISR once per absorbed response: next = {misr[6:0], misr[7]^misr[3]^misr[2]^misr[1]} XOR response.
REQ-021 SHALL apply exactly num_pat patterns; leave RUN after the cycle in which the counter equals num_pat-1; counter wraps never (CNT_W-bit compare).
REQ-022 SHALL ignore start outside IDLE, including in the DONE cycle.
REQ-023 SHALL, in DONE, set done=1 and pass=(signature==golden) for that cycle's golden, then return to IDLE.
REQ-024 SHALL keep signature stable from DONE until the next accepted start.

Reset
REQ-025 SHALL, on rst asserted at any time including mid-session, immediately force state IDLE, cut_pi=0, LFSR=0x001, MISR=0, counter=0, busy=0, done=0, pass=0.
REQ-026 SHALL resume normal behaviour on the first clock edge after rst deasserts; no partial session is resumed.

Configuration
REQ-027 SHALL, with BIST_CAPTURE_REG_EN defined, register cut_po before the MISR (MISR absorbs the response to the previous cycle's pattern) and insert exactly one DRAIN cycle absorbing the final response.
REQ-028 SHALL, without BIST_CAPTURE_REG_EN, absorb cut_po combinationally in the same RUN cycle and transition RUN -> DONE directly with no DRAIN state.

Structure
REQ-029 SHALL place the FSM state enum, LFSR/MISR tap constants, and default widths in package bist_pkg.
REQ-030 SHALL implement the MISR as sub-module bist_misr (inputs clk, rst, clr, en, din; output sig).

Verification
REQ-031 SHALL cover: seed=0x001, num_pat=3 -> cut_pi sequence 0x001, 0x003, 0x007, then done pulse.
REQ-032 SHALL cover: cut_po tied 0x01, num_pat=2, golden=0x03 -> signature=0x03, pass=1; golden=0x04 -> pass=0.
REQ-033 SHALL cover: num_pat=0, golden=0x00 -> DONE one cycle after start, busy never high, pass=1.
REQ-034 SHALL cover: seed=0x000 -> first cut_pi=0x001; start pulsed during RUN -> no restart, pattern count unchanged.
REQ-035 SHALL cover: rst asserted mid-RUN -> all outputs at reset values same cycle; new start afterwards gives sequence identical to a fresh session.
REQ-036 SHALL cover both builds (BIST_CAPTURE_REG_EN on/off): busy length = num_pat (+1 with macro) cycles, signatures identical for a constant cut_po.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern sequencer: FSM states,
// LFSR/MISR tap masks and default widths.
package bist_pkg;

  localparam int unsigned PI_W_DEF  = 12;
  localparam int unsigned PO_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // x^12+x^6+x^4+x+1 as a Fibonacci feedback mask over bits 11,5,3,0
  localparam logic [11:0] LFSR_TAPS  = 12'h829;
  localparam logic [11:0] LFSR_RESET = 12'h001;

  // MISR feedback over bits 7,3,2,1
  localparam logic [7:0] MISR_TAPS = 8'h8E;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } bist_state_e;

  function automatic logic [11:0] lfsr_seed_fix(input logic [11:0] seed);
    return (seed == 12'h000) ? LFSR_RESET : seed;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with XOR feedback, fold in din when en.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned W = PO_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  localparam logic [W-1:0] Taps = W'(MISR_TAPS);

  logic [W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[W-2:0], ^(sig & Taps)} ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_seq.sv
// BIST sequencer: LFSR patterns into a combinational CUT, responses compacted by a MISR.
// Define BIST_CAPTURE_REG_EN to register cut_po before the MISR (adds one DRAIN cycle).
module bist_seq
  import bist_pkg::*;
#(
  parameter int unsigned PI_W  = PI_W_DEF,
  parameter int unsigned PO_W  = PO_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [PI_W-1:0]  seed,
  input  logic [PO_W-1:0]  golden,
  output logic [PI_W-1:0]  cut_pi,
  input  logic [PO_W-1:0]  cut_po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [PO_W-1:0]  signature
);

  localparam logic [PI_W-1:0] LfsrTaps  = PI_W'(LFSR_TAPS);
  localparam logic [PI_W-1:0] LfsrReset = PI_W'(LFSR_RESET);

`ifdef BIST_CAPTURE_REG_EN
  localparam bist_state_e LastRunNext = StDrain;
`else
  localparam bist_state_e LastRunNext = StDone;
`endif

  bist_state_e      state_q;
  logic [PI_W-1:0]  lfsr_q;
  logic [PI_W-1:0]  pi_hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_pat_q;
  logic             pass_q;

  logic [PI_W-1:0]  lfsr_next;
  logic [PI_W-1:0]  seed_eff;
  logic             last_pat;
  logic             start_ok;
  logic             sig_match;
  logic             misr_en;
  logic [PO_W-1:0]  misr_din;

  always_comb begin
    lfsr_next = {lfsr_q[PI_W-2:0], ^(lfsr_q & LfsrTaps)};
    seed_eff  = (seed == '0) ? LfsrReset : seed;
    last_pat  = (cnt_q == (num_pat_q - CNT_W'(1)));
    start_ok  = (state_q == StIdle) && start;
    sig_match = (signature == golden);
  end

`ifdef BIST_CAPTURE_REG_EN
  logic [PO_W-1:0] cap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (state_q == StRun) begin
      cap_q <= cut_po;
    end
  end

  // First RUN cycle has no captured response yet; DRAIN absorbs the last one.
  always_comb begin
    misr_en  = ((state_q == StRun) && (cnt_q != '0)) || (state_q == StDrain);
    misr_din = cap_q;
  end
`else
  always_comb begin
    misr_en  = (state_q == StRun);
    misr_din = cut_po;
  end
`endif

  bist_misr #(
    .W (PO_W)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (misr_en),
    .din (misr_din),
    .sig (signature)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      lfsr_q    <= LfsrReset;
      pi_hold_q <= '0;
      cnt_q     <= '0;
      num_pat_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_q    <= seed_eff;
            cnt_q     <= '0;
            num_pat_q <= num_pat;
            pass_q    <= 1'b0;
            state_q   <= (num_pat == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          lfsr_q    <= lfsr_next;
          pi_hold_q <= lfsr_q;
          // Counter stops at num_pat-1 so it can never wrap.
          if (last_pat) begin
            state_q <= LastRunNext;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDrain: begin
          state_q <= StDone;
        end
        StDone: begin
          pass_q  <= sig_match;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy   = (state_q == StRun) || (state_q == StDrain);
    done   = (state_q == StDone);
    pass   = (state_q == StDone) ? sig_match : pass_q;
    cut_pi = (state_q == StRun) ? lfsr_q : pi_hold_q;
  end

endmodule
